// File: rtl/exp_scheduler_if.sv
// Requester-side bus of exp_scheduler: per-requester job requests and the shared result channel.
// Requesters use the master modport; the scheduler uses the slave modport.
interface exp_scheduler_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_base;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_exp;
   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [ID_W-1:0]               rsp_id;
   logic [DATA_WIDTH-1:0]         rsp_data;
   logic                          rsp_err;

   modport master (
      output req_valid, req_base, req_exp, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_base, req_exp, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );
endinterface

// File: rtl/exp_scheduler.sv
// Round-robin scheduler sharing one modular exponentiation unit among NUM_REQ requesters.
// Define EXP_SCHED_TIMEOUT_EN to build the WAIT-state watchdog (TIMEOUT_CYCLES).
module exp_scheduler #(
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cfg_we,
   input  logic [DATA_WIDTH-1:0] cfg_modulant,
   input  logic [DATA_WIDTH-1:0] cfg_r_div_two,
   input  logic [DATA_WIDTH-1:0] cfg_r_squared,
   output logic                  cfg_busy,
   exp_scheduler_if.slave        req_bus,
   output logic [DATA_WIDTH-1:0] exp_a,
   output logic [DATA_WIDTH-1:0] exp_b,
   output logic [DATA_WIDTH-1:0] exp_modulant,
   output logic [DATA_WIDTH-1:0] exp_r_div_two,
   output logic [DATA_WIDTH-1:0] exp_r_squared,
   output logic                  exp_set,
   input  logic [DATA_WIDTH-1:0] exp_out,
   input  logic                  exp_finished,
   output logic [1:0]            dbg_state_o,
   output logic                  dbg_cfg_loaded_o
);

   localparam int CW = ID_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                state_q;
   logic                  cfg_loaded_q;
   logic [DATA_WIDTH-1:0] modulant_q, r_div_two_q, r_squared_q;
   logic [ID_W-1:0]       rr_last_q, cur_id_q, rsp_id_q;
   logic [DATA_WIDTH-1:0] exp_a_q, exp_b_q, rsp_data_q;
   logic                  exp_set_q, rsp_valid_q, rsp_err_q;

   logic                  grant_found, grant_en;
   logic [ID_W-1:0]       grant_idx_d;
   logic [CW-1:0]         cand;
   logic [DATA_WIDTH-1:0] grant_base_d, grant_exp_d;

   // First valid requester after rr_last_q, wrapping at NUM_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx_d = '0;
      cand        = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = {1'b0, rr_last_q} + CW'(i);
         if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
         if (!grant_found && req_bus.req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx_d = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      grant_base_d = '0;
      grant_exp_d  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (grant_idx_d == ID_W'(j)) begin
            grant_base_d = req_bus.req_base[j*DATA_WIDTH +: DATA_WIDTH];
            grant_exp_d  = req_bus.req_exp[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Handshakes: a request transfers in the cycle req_valid[i] and req_ready[i] are both high;
   // a result transfers in the cycle rsp_valid and rsp_ready are both high. Nothing is queued.
   assign grant_en = reset_n && (state_q == IDLE) && cfg_loaded_q && !cfg_we && grant_found;
   assign req_bus.req_ready = grant_en ? (NUM_REQ'(1) << grant_idx_d) : '0;

`ifdef EXP_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cfg_loaded_q <= 1'b0;
         modulant_q   <= '0;
         r_div_two_q  <= '0;
         r_squared_q  <= '0;
         rr_last_q    <= ID_W'(NUM_REQ - 1);
         cur_id_q     <= '0;
         rsp_id_q     <= '0;
         exp_a_q      <= '0;
         exp_b_q      <= '0;
         rsp_data_q   <= '0;
         exp_set_q    <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
`ifdef EXP_SCHED_TIMEOUT_EN
         to_cnt_q     <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (cfg_we) begin
                  modulant_q   <= cfg_modulant;
                  r_div_two_q  <= cfg_r_div_two;
                  r_squared_q  <= cfg_r_squared;
                  cfg_loaded_q <= 1'b1;
               end else if (grant_en) begin
                  exp_a_q   <= grant_base_d;
                  exp_b_q   <= grant_exp_d;
                  cur_id_q  <= grant_idx_d;
                  exp_set_q <= 1'b1;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               exp_set_q <= 1'b0;
               state_q   <= WAIT;
`ifdef EXP_SCHED_TIMEOUT_EN
               to_cnt_q  <= '0;
`endif
            end
            WAIT: begin
               // exp_finished may be stale from an earlier job until our set is seen; it is only read here.
               if (exp_finished) begin
                  rsp_data_q  <= exp_out;
                  rsp_id_q    <= cur_id_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
`ifdef EXP_SCHED_TIMEOUT_EN
               else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_data_q  <= '0;
                  rsp_id_q    <= cur_id_q;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  to_cnt_q <= to_cnt_q + TW'(1);
               end
`endif
            end
            RESP: begin
               if (req_bus.rsp_ready) begin
                  rr_last_q   <= cur_id_q;
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cfg_busy          = reset_n && (state_q != IDLE);
   assign exp_a             = exp_a_q;
   assign exp_b             = exp_b_q;
   assign exp_set           = exp_set_q;
   assign exp_modulant      = modulant_q;
   assign exp_r_div_two     = r_div_two_q;
   assign exp_r_squared     = r_squared_q;
   assign req_bus.rsp_valid = rsp_valid_q;
   assign req_bus.rsp_id    = rsp_id_q;
   assign req_bus.rsp_data  = rsp_data_q;
   assign req_bus.rsp_err   = rsp_err_q;
   assign dbg_state_o       = state_q;
   assign dbg_cfg_loaded_o  = cfg_loaded_q;

endmodule

// File: doc/exp_scheduler.md
Name: exp_scheduler

Overview:
- Shares one modular exponentiation unit (Montgomery datapath; `set` / `finished` / `out` interface) among NUM_REQ requesters.
- Requesters are served by round-robin arbitration.
- Holds the shared modulus configuration (modulant, R/2, R²) and drives it onto the unit.
- Sequences each job: latch operands, pulse `set`, wait for `finished`, return the result to the requester with its id.
- Sits between the crypto command front-end and the exponentiation datapath.

Parameters:
- DATA_WIDTH, 8, operand/result width; must match the exponentiation unit.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must satisfy 2^ID_W >= NUM_REQ.
- TIMEOUT_CYCLES, 32, WAIT-state watchdog limit; used only with EXP_SCHED_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- cfg_we  in  1  configuration write strobe.
- cfg_modulant  in  DATA_WIDTH  modulus.
- cfg_r_div_two  in  DATA_WIDTH  R/2 constant.
- cfg_r_squared  in  DATA_WIDTH  R² mod modulus.
- cfg_busy  out  1  high when state != IDLE.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_base  in  NUM_REQ*DATA_WIDTH  bases, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_exp  in  NUM_REQ*DATA_WIDTH  exponents, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumed.
- rsp_id  out  ID_W  requester index of the result.
- rsp_data  out  DATA_WIDTH  result.
- rsp_err  out  1  timeout flag.
- exp_a  out  DATA_WIDTH  base to unit.
- exp_b  out  DATA_WIDTH  exponent to unit.
- exp_modulant  out  DATA_WIDTH  to unit.
- exp_r_div_two  out  DATA_WIDTH  to unit.
- exp_r_squared  out  DATA_WIDTH  to unit.
- exp_set  out  1  start pulse to unit.
- exp_out  in  DATA_WIDTH  unit result.
- exp_finished  in  1  unit done flag.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous, active-low, and overrides everything, including mid-job.
  - Reset state: IDLE; cfg_loaded=0; config registers=0; rr_last=NUM_REQ-1 (requester 0 wins first).
  - All outputs are 0 during and directly after reset.
  - The exponentiation unit has no reset. The scheduler ignores exp_finished until it has issued its own exp_set.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If cfg_we=1: load the three config registers and set cfg_loaded=1. No grant is made that cycle.
  - Else, if cfg_loaded=1 and any req_valid is high:
    - Grant the first valid requester searching rr_last+1, rr_last+2, ... (wrapping).
    - Assert req_ready[g] combinationally in that cycle.
    - Latch req_base[g], req_exp[g] and g into exp_a, exp_b and cur_id.
    - Go to ISSUE.
  - req_valid is ignored while cfg_loaded=0.
- ISSUE:
  - exp_set=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - exp_set=0.
  - When exp_finished=1: capture exp_out into rsp_data, set rsp_id=cur_id, go to RESP.
  - exp_finished is never sampled in the ISSUE cycle.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable.
  - When rsp_ready=1: set rr_last=cur_id, rsp_valid=0 on the next cycle, go to IDLE.
  - rsp_ready while rsp_valid=0 has no effect.
- Handshake rules:
  - req_ready is 0 in every state except the IDLE grant cycle.
  - cfg_we outside IDLE is ignored. Config registers drive exp_modulant / exp_r_div_two / exp_r_squared continuously.
- Latency (with the real unit):
  - Request accepted at cycle t; exp_set is high at t+1.
  - exp_finished is first high at t+3+k, where k=floor(log2(b)) for b>=1 and k=0 for b=0.
  - rsp_valid is high from t+4+k.
  - The next grant occurs no earlier than the cycle after the rsp_ready handshake.
- A requester that drops req_valid before its grant loses nothing. Requests are not queued.

Optional Feature:
- Macro: EXP_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without exp_finished: go to RESP with rsp_data=0 and rsp_err=1.
  - rsp_err clears on the RESP handshake.
- Undefined:
  - No counter is built; WAIT waits indefinitely.
  - rsp_err is tied to 0; the port is always present.

Test Plan:
1. Reset, then req_valid=4'b0001 with no cfg_we -> req_ready stays 0 and state stays IDLE. Write cfg_modulant=13 -> the next cycle grants req 0; exp_modulant=13.
2. Stub unit with finished 3 cycles after set. req 2 with base=5, exp=0, and exp_out=0x2A -> exactly one exp_set pulse; rsp_valid=1 with rsp_id=2 and rsp_data=0x2A, held until rsp_ready.
3. req_valid=4'b1111 held with rsp_ready=1 -> grant order 0,1,2,3,0. Exactly one req_ready bit is high per grant.
4. Real exponentiation unit, b=8 (k=3), accept at t -> rsp_valid at t+7; rsp_data equals exp_out at the finished cycle.
5. Assert reset_n=0 in WAIT -> next cycle: IDLE, rsp_valid=0, cfg_loaded=0; a subsequent request is refused until cfg_we.
6. EXP_SCHED_TIMEOUT_EN defined, TIMEOUT_CYCLES=32, stub never asserts finished -> RESP after 32 WAIT cycles with rsp_err=1 and rsp_data=0. With the macro undefined, the design stays in WAIT and rsp_err=0.
